// File: rtl/count_sequencer.sv
// count_sequencer: steps the period counter's switch input through up to
// four programmed phases, each lasting a set number of o_valid ticks.
module count_sequencer #(
   parameter int unsigned           TICK_WIDTH = 8,
   parameter int unsigned           N_PHASES   = 4,
   parameter logic [1:0]            PH0_SEL    = 2'd0,
   parameter logic [TICK_WIDTH-1:0] PH0_TICKS  = TICK_WIDTH'(4),
   parameter logic [1:0]            PH1_SEL    = 2'd1,
   parameter logic [TICK_WIDTH-1:0] PH1_TICKS  = TICK_WIDTH'(2),
   parameter logic [1:0]            PH2_SEL    = 2'd2,
   parameter logic [TICK_WIDTH-1:0] PH2_TICKS  = TICK_WIDTH'(3),
   parameter logic [1:0]            PH3_SEL    = 2'd3,
   parameter logic [TICK_WIDTH-1:0] PH3_TICKS  = TICK_WIDTH'(1)
) (
   input  logic                  clock,
   input  logic                  i_reset,
   input  logic                  i_start,
   input  logic                  i_stop,
   input  logic                  i_pause,
   input  logic                  i_loop,
   input  logic                  i_tick,
   output logic [2:0]            o_sw,
   output logic [1:0]            o_phase,
   output logic [TICK_WIDTH-1:0] o_tick_cnt,
   output logic                  o_phase_end,
   output logic                  o_busy,
   output logic                  o_done
);

   localparam logic [1:0] LAST_PHASE = 2'(N_PHASES - 1);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

   state_t                state, state_nx;
   logic [2:0]            sw_nx;
   logic [1:0]            phase_nx;
   logic [TICK_WIDTH-1:0] cnt_nx;
   logic                  pe_nx, busy_nx, done_nx;
   logic [TICK_WIDTH-1:0] cnt_inc;
   logic                  seq_finish;

   function automatic logic [1:0] sel_of(input logic [1:0] p);
      case (p)
         2'd0:    sel_of = PH0_SEL;
         2'd1:    sel_of = PH1_SEL;
         2'd2:    sel_of = PH2_SEL;
         default: sel_of = PH3_SEL;
      endcase
   endfunction

   function automatic logic [TICK_WIDTH-1:0] ticks_of(input logic [1:0] p);
      case (p)
         2'd0:    ticks_of = PH0_TICKS;
         2'd1:    ticks_of = PH1_TICKS;
         2'd2:    ticks_of = PH2_TICKS;
         default: ticks_of = PH3_TICKS;
      endcase
   endfunction

   // Next-state and next-output computation; stop beats start beats pause beats tick.
   always_comb begin
      state_nx   = state;
      sw_nx      = o_sw;
      phase_nx   = o_phase;
      cnt_nx     = o_tick_cnt;
      pe_nx      = 1'b0;
      busy_nx    = o_busy;
      done_nx    = o_done;
      seq_finish = 1'b0;
      cnt_inc    = TICK_WIDTH'(o_tick_cnt + TICK_WIDTH'(1));

      if (i_stop) begin
         state_nx = IDLE;
         sw_nx    = 3'b000;
         phase_nx = 2'd0;
         cnt_nx   = '0;
         busy_nx  = 1'b0;
         done_nx  = 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (i_start) begin
                  state_nx = RUN;
                  phase_nx = 2'd0;
                  cnt_nx   = '0;
                  sw_nx    = {PH0_SEL, 1'b1};
                  busy_nx  = 1'b1;
                  done_nx  = 1'b0;
               end
            end
            RUN: begin
               // A tick coinciding with pause is still counted.
               if (i_tick) begin
                  if (cnt_inc != ticks_of(o_phase)) begin
                     cnt_nx = cnt_inc;
                  end else begin
                     pe_nx  = 1'b1;
                     cnt_nx = '0;
                     if (o_phase != LAST_PHASE)
                        phase_nx = 2'(o_phase + 2'd1);
                     else if (i_loop)
                        phase_nx = 2'd0;
                     else
                        seq_finish = 1'b1;
                  end
               end
               if (seq_finish) begin
                  state_nx = DONE;
                  sw_nx    = {sel_of(o_phase), 1'b0};
                  busy_nx  = 1'b0;
                  done_nx  = 1'b1;
               end else if (i_pause) begin
                  state_nx = PAUSE;
                  sw_nx    = {sel_of(phase_nx), 1'b0};
               end else begin
                  sw_nx    = {sel_of(phase_nx), 1'b1};
               end
            end
            PAUSE: begin
               if (!i_pause) begin
                  state_nx = RUN;
                  sw_nx    = {o_sw[2:1], 1'b1};
               end
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!i_reset) begin
         state       <= IDLE;
         o_sw        <= 3'b000;
         o_phase     <= 2'd0;
         o_tick_cnt  <= '0;
         o_phase_end <= 1'b0;
         o_busy      <= 1'b0;
         o_done      <= 1'b0;
      end else begin
         state       <= state_nx;
         o_sw        <= sw_nx;
         o_phase     <= phase_nx;
         o_tick_cnt  <= cnt_nx;
         o_phase_end <= pe_nx;
         o_busy      <= busy_nx;
         o_done      <= done_nx;
      end
   end

endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer with default phase programming.
module tb_count_sequencer;

   logic       clock = 1'b0;
   logic       i_reset, i_start, i_stop, i_pause, i_loop, i_tick;
   logic [2:0] o_sw;
   logic [1:0] o_phase;
   logic [7:0] o_tick_cnt;
   logic       o_phase_end, o_busy, o_done;

   int n_vec = 0;
   int n_err = 0;
   int pe_count = 0;

   count_sequencer dut (
      .clock       (clock),
      .i_reset     (i_reset),
      .i_start     (i_start),
      .i_stop      (i_stop),
      .i_pause     (i_pause),
      .i_loop      (i_loop),
      .i_tick      (i_tick),
      .o_sw        (o_sw),
      .o_phase     (o_phase),
      .o_tick_cnt  (o_tick_cnt),
      .o_phase_end (o_phase_end),
      .o_busy      (o_busy),
      .o_done      (o_done)
   );

   always #5 clock = ~clock;

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One tick pulse followed by four quiet cycles; counts phase-end pulses.
   task automatic give_tick();
      i_tick = 1'b1;
      cyc();
      i_tick = 1'b0;
      if (o_phase_end === 1'b1) pe_count++;
      repeat (4) cyc();
   endtask

   task automatic give_ticks(input int n);
      for (int k = 0; k < n; k++) give_tick();
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_sw"},    32'(o_sw), 32'd0);
      check({tag, "_phase"}, 32'(o_phase), 32'd0);
      check({tag, "_cnt"},   32'(o_tick_cnt), 32'd0);
      check({tag, "_pe"},    32'(o_phase_end), 32'd0);
      check({tag, "_busy"},  32'(o_busy), 32'd0);
      check({tag, "_done"},  32'(o_done), 32'd0);
   endtask

   initial begin
      i_reset = 1'b0; i_start = 1'b0; i_stop = 1'b0;
      i_pause = 1'b0; i_loop = 1'b0; i_tick = 1'b0;
      cyc(); cyc();
      check_zero("reset");
      i_reset = 1'b1;

      // 1: one-shot run through all four phases
      i_start = 1'b1; cyc(); i_start = 1'b0;
      check("t1_start_sw", 32'(o_sw), 32'b001);
      check("t1_start_busy", 32'(o_busy), 32'd1);
      give_ticks(3);
      check("t1_cnt3", 32'(o_tick_cnt), 32'd3);
      check("t1_ph0_sw", 32'(o_sw), 32'b001);
      give_ticks(1);
      check("t1_ph1_phase", 32'(o_phase), 32'd1);
      check("t1_ph1_sw", 32'(o_sw), 32'b011);
      check("t1_ph1_cnt", 32'(o_tick_cnt), 32'd0);
      give_ticks(2);
      check("t1_ph2_sw", 32'(o_sw), 32'b101);
      give_ticks(3);
      check("t1_ph3_sw", 32'(o_sw), 32'b111);
      check("t1_ph3_phase", 32'(o_phase), 32'd3);
      give_ticks(1);
      check("t1_done", 32'(o_done), 32'd1);
      check("t1_done_busy", 32'(o_busy), 32'd0);
      check("t1_done_sw", 32'(o_sw), 32'b110);
      check("t1_done_phase", 32'(o_phase), 32'd3);
      check("t1_pe_count", 32'(pe_count), 32'd4);
      give_ticks(1);
      check("t1_done_tick_ignored", 32'(o_done), 32'd1);
      check("t1_done_cnt", 32'(o_tick_cnt), 32'd0);

      // 2: looping, 20 ticks from DONE restart
      i_loop = 1'b1; pe_count = 0;
      i_start = 1'b1; cyc(); i_start = 1'b0;
      check("t2_restart_sw", 32'(o_sw), 32'b001);
      check("t2_restart_done", 32'(o_done), 32'd0);
      check("t2_restart_phase", 32'(o_phase), 32'd0);
      give_ticks(10);
      check("t2_lap1_phase", 32'(o_phase), 32'd0);
      check("t2_lap1_sw", 32'(o_sw), 32'b001);
      check("t2_lap1_busy", 32'(o_busy), 32'd1);
      check("t2_lap1_pe", 32'(pe_count), 32'd4);
      give_ticks(6);
      check("t2_mid_phase", 32'(o_phase), 32'd2);
      check("t2_mid_sw", 32'(o_sw), 32'b101);
      give_ticks(4);
      check("t2_lap2_phase", 32'(o_phase), 32'd0);
      check("t2_lap2_done", 32'(o_done), 32'd0);
      check("t2_lap2_busy", 32'(o_busy), 32'd1);
      check("t2_lap2_pe", 32'(pe_count), 32'd8);

      // 3: pause in phase 0 with ticks injected while paused
      give_ticks(2);
      check("t3_cnt2", 32'(o_tick_cnt), 32'd2);
      i_pause = 1'b1; cyc();
      check("t3_pause_sw", 32'(o_sw), 32'b000);
      check("t3_pause_busy", 32'(o_busy), 32'd1);
      for (int i = 0; i < 9; i++) begin
         i_tick = (i == 1 || i == 4 || i == 7);
         cyc();
         i_tick = 1'b0;
      end
      check("t3_hold_cnt", 32'(o_tick_cnt), 32'd2);
      check("t3_hold_sw", 32'(o_sw), 32'b000);
      check("t3_hold_phase", 32'(o_phase), 32'd0);
      i_pause = 1'b0; cyc();
      check("t3_resume_sw", 32'(o_sw), 32'b001);
      check("t3_resume_cnt", 32'(o_tick_cnt), 32'd2);
      give_ticks(1);
      check("t3_cnt3", 32'(o_tick_cnt), 32'd3);

      // 4: tick and pause together at the phase boundary
      i_tick = 1'b1; i_pause = 1'b1; cyc(); i_tick = 1'b0;
      check("t4_phase", 32'(o_phase), 32'd1);
      check("t4_pe", 32'(o_phase_end), 32'd1);
      check("t4_sw", 32'(o_sw), 32'b010);
      check("t4_cnt", 32'(o_tick_cnt), 32'd0);
      cyc();
      check("t4_pe_drop", 32'(o_phase_end), 32'd0);
      check("t4_still_paused", 32'(o_sw), 32'b010);
      i_pause = 1'b0; cyc();
      check("t4_resume_sw", 32'(o_sw), 32'b011);

      // 5: stop with start mid-phase 2
      give_ticks(2);
      give_ticks(1);
      check("t5_ph2_cnt", 32'(o_tick_cnt), 32'd1);
      check("t5_ph2_sw", 32'(o_sw), 32'b101);
      i_stop = 1'b1; i_start = 1'b1; cyc();
      check_zero("t5_stop");
      i_stop = 1'b0; i_start = 1'b0;
      repeat (3) cyc();
      check("t5_idle_sw", 32'(o_sw), 32'b000);
      check("t5_idle_busy", 32'(o_busy), 32'd0);
      i_start = 1'b1; cyc(); i_start = 1'b0;
      check("t5_restart_sw", 32'(o_sw), 32'b001);
      check("t5_restart_busy", 32'(o_busy), 32'd1);

      // 6: synchronous reset during phase 3
      give_ticks(9);
      check("t6_ph3_sw", 32'(o_sw), 32'b111);
      check("t6_ph3_phase", 32'(o_phase), 32'd3);
      i_reset = 1'b0;
      #3;
      check("t6_pre_edge_sw", 32'(o_sw), 32'b111);
      check("t6_pre_edge_busy", 32'(o_busy), 32'd1);
      cyc();
      check_zero("t6_reset");
      i_reset = 1'b1;
      cyc();
      check("t6_post_reset_sw", 32'(o_sw), 32'b000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/count_sequencer.md
Name: count_sequencer

Overview:
- Controller that drives the 3-bit switch input of the period counter/compare datapath (`count`) through a programmed sequence of up to 4 phases.
- Each phase selects one of the 4 mux periods (`sel` -> switch bits [2:1]), enables counting (switch bit [0]) and lasts a programmed number of `o_valid` ticks.
- Supports start/stop/pause and one-shot or looping operation.
- Sits between top-level controls and the `count` instance: `o_sw` feeds `i_sw`, and `count.o_valid` feeds `i_tick`.

Parameters:
- TICK_WIDTH, 8, width of per-phase tick counter and tick-count parameters.
- N_PHASES, 4, number of active phases; legal 1..4.
- PH0_SEL, 2'd0, period select for phase 0.
- PH0_TICKS, 8'd4, ticks in phase 0.
- PH1_SEL, 2'd1, period select for phase 1.
- PH1_TICKS, 8'd2, ticks in phase 1.
- PH2_SEL, 2'd2, period select for phase 2.
- PH2_TICKS, 8'd3, ticks in phase 2.
- PH3_SEL, 2'd3, period select for phase 3.
- PH3_TICKS, 8'd1, ticks in phase 3.

Ports:
- clock  input  1  single system clock; all logic on rising edge.
- i_reset  input  1  synchronous, active-low reset (0 at posedge resets the block).
- i_start  input  1  level; starts the sequence from phase 0 when in IDLE or DONE.
- i_stop  input  1  level; aborts to IDLE.
- i_pause  input  1  level; holds the sequence while high.
- i_loop  input  1  1 = wrap to phase 0 after last phase; 0 = one-shot. Sampled at the last-phase boundary.
- i_tick  input  1  single-cycle pulse from `count.o_valid`.
- o_sw  output  3  {sel[1:0], enable} to `count.i_sw`.
- o_phase  output  2  current phase index.
- o_tick_cnt  output  TICK_WIDTH  ticks elapsed in current phase.
- o_phase_end  output  1  one-cycle pulse when a phase completes.
- o_busy  output  1  high in RUN or PAUSE.
- o_done  output  1  high in DONE.

Behaviour:
- All outputs are registered.
- **Reset** (`i_reset`=0 at posedge), regardless of state:
  - state=IDLE, o_sw=3'b000, o_phase=0, o_tick_cnt=0, o_phase_end=0, o_busy=0, o_done=0.
  - Reset overrides all other inputs, including mid-sequence.
- **States:** IDLE, RUN, PAUSE, DONE.
- **Priority each cycle:** reset > i_stop > i_start > i_pause > i_tick.
- **IDLE:**
  - o_sw[0]=0; o_sw[2:1] = 0.
  - i_start=1 -> RUN next cycle with o_phase=0, o_tick_cnt=0, o_sw={PH0_SEL,1}, o_busy=1 (1-cycle latency).
- **RUN:**
  - o_sw={SEL(o_phase),1}.
  - On i_tick: next = o_tick_cnt+1, computed mod 2^TICK_WIDTH.
  - If next != TICKS(o_phase): o_tick_cnt <= next.
  - If next == TICKS(o_phase): o_phase_end=1 for the following cycle, o_tick_cnt <= 0, and:
    - o_phase < N_PHASES-1: o_phase+1; o_sw[2:1] updates in the same edge.
    - Last phase and i_loop=1: o_phase <= 0; stay in RUN.
    - Last phase and i_loop=0: -> DONE, o_sw <= {SEL(last),0}.
  - TICKS=0 is equivalent to 2^TICK_WIDTH ticks, a consequence of the wrap compare.
  - i_start ignored.
- **PAUSE entry/exit:**
  - i_pause=1 in RUN -> PAUSE; o_sw[0] <= 0; sel, o_phase and o_tick_cnt held.
  - A tick arriving in the same cycle as i_pause is still counted, including any phase completion.
- **PAUSE:**
  - i_tick ignored.
  - i_pause=0 -> RUN; o_sw[0] <= 1.
  - i_start ignored.
- **DONE:**
  - o_done=1, o_busy=0, o_sw[0]=0; o_phase, sel held.
  - i_start -> RUN at phase 0, o_done <= 0.
- **i_stop** in RUN/PAUSE/DONE -> IDLE with reset values, except that reset is not required for the next i_start.
- **i_start and i_stop both high:** stop wins; i_start must be re-asserted after stop drops.
- **N_PHASES=1:** phase 0 repeats (loop) or finishes (one-shot); o_phase stays 0.
- **o_phase_end timing:** coincides with the cycle in which the new phase and sel are visible. It does not fire on stop, pause or reset.

Test Plan:
1. Reset, then i_start pulse, i_loop=0, ticks every 5 cycles with default parameters -> o_sw sequence 001,011,101,111 with 4/2/3/1 ticks each. o_phase_end pulses 4 times, then DONE: o_done=1, o_sw=110.
2. i_loop=1, same stimulus for 20 ticks -> phases 0,1,2,3,0,1,2,3 (10 ticks per lap). No DONE; o_busy stays 1.
3. In phase 0 after 2 ticks, i_pause high for 10 cycles with 3 ticks injected -> o_sw=000, o_tick_cnt holds 2. After release, o_sw=001 and 2 more ticks end the phase.
4. i_tick and i_pause in the same cycle at o_tick_cnt=3 in phase 0 -> phase 0 ends: o_phase=1, o_phase_end=1, state PAUSE, o_sw=010.
5. i_stop mid-phase 2, with i_start high in the same cycle -> IDLE next cycle, all outputs 0. The sequence restarts at phase 0 only on a later i_start.
6. i_reset=0 for 1 cycle during RUN phase 3 -> next cycle all outputs 0. Check the reset is synchronous: outputs do not change before the clock edge.
